// File: rtl/pipe_acc_core.sv
// Three-stage (Fetch / Decode-Read / Execute) accumulator core with synchronous external memories.
// Optional macro PIPE_ACC_FWD_EN: store-to-load forwarding instead of a one-cycle interlock.
module pipe_acc_core #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 12
) (
  input  logic          clk1,
  input  logic          rst_n,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic [AW-1:0] dmem_raddr,
  input  logic [DW-1:0] dmem_rdata,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_waddr,
  output logic [DW-1:0] dmem_wdata,
  output logic [DW-1:0] acc,
  output logic          carry,
  output logic          halted,
  output logic [31:0]   retired
);

  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpLda  = 4'h2;
  localparam logic [3:0] OpSta  = 4'h3;
  localparam logic [3:0] OpAdd  = 4'h4;
  localparam logic [3:0] OpJmp  = 4'h5;
  localparam logic [3:0] OpJz   = 4'h6;
  localparam logic [3:0] OpSub  = 4'h7;
  localparam logic [3:0] OpAnd  = 4'h8;
  localparam logic [3:0] OpOr   = 4'h9;
  localparam logic [3:0] OpXor  = 4'hA;
  localparam logic [3:0] OpAddi = 4'hB;
  localparam logic [3:0] OpHlt  = 4'hF;

  logic [AW-1:0] pc_q;
  logic          d_valid_q;
  logic          d_hold_q;
  logic [DW-1:0] d_hold_instr_q;
  logic          e_valid_q;
  logic [DW-1:0] e_instr_q;
  logic [DW-1:0] acc_q, acc_d;
  logic          carry_q, carry_d;
  logic          halted_q;
  logic [31:0]   retired_q;

  logic [DW-1:0] d_instr;
  logic [3:0]    d_op, e_op;
  logic [AW-1:0] d_a, e_a;
  logic [DW-1:0] e_imm, e_mem;
  logic          d_reads, e_sta, e_taken, e_halt, hazard, stall;
  logic [DW:0]   sum_mem, sum_imm, diff_mem;

  // While stalled the imem has already moved on, so D replays its own copy.
  assign d_instr = d_hold_q ? d_hold_instr_q : imem_rdata;
  assign d_op    = d_instr[DW-1:DW-4];
  assign d_a     = d_instr[AW-1:0];
  assign e_op    = e_instr_q[DW-1:DW-4];
  assign e_a     = e_instr_q[AW-1:0];
  assign e_imm   = {{(DW-AW){1'b0}}, e_a};

  assign d_reads = d_valid_q && (d_op == OpLda || d_op == OpAdd || d_op == OpSub ||
                                 d_op == OpAnd || d_op == OpOr  || d_op == OpXor);
  assign e_sta   = e_valid_q && (e_op == OpSta);
  assign e_taken = e_valid_q && ((e_op == OpJmp) || (e_op == OpJz && acc_q == '0));
  assign e_halt  = e_valid_q && (e_op == OpHlt);
  assign hazard  = d_reads && e_sta && (d_a == e_a);

`ifdef PIPE_ACC_FWD_EN
  logic          e_fwd_q;
  logic [DW-1:0] e_fwd_data_q;
  assign stall = 1'b0;
  assign e_mem = e_fwd_q ? e_fwd_data_q : dmem_rdata;
`else
  assign stall = hazard;
  assign e_mem = dmem_rdata;
`endif

  assign imem_addr  = pc_q;
  assign dmem_raddr = d_valid_q ? d_a : '0;
  assign dmem_we    = e_sta;
  assign dmem_waddr = e_sta ? e_a : '0;
  assign dmem_wdata = e_sta ? acc_q : '0;
  assign acc        = acc_q;
  assign carry      = carry_q;
  assign halted     = halted_q;
  assign retired    = retired_q;

  assign sum_mem  = {1'b0, acc_q} + {1'b0, e_mem};
  assign sum_imm  = {1'b0, acc_q} + {1'b0, e_imm};
  // Top bit of the widened difference is the borrow.
  assign diff_mem = {1'b0, acc_q} - {1'b0, e_mem};

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    case (e_op)
      OpLdi:   acc_d = e_imm;
      OpLda:   acc_d = e_mem;
      OpAdd:   {carry_d, acc_d} = sum_mem;
      OpSub:   {carry_d, acc_d} = diff_mem;
      OpAnd:   acc_d = acc_q & e_mem;
      OpOr:    acc_d = acc_q | e_mem;
      OpXor:   acc_d = acc_q ^ e_mem;
      OpAddi:  {carry_d, acc_d} = sum_imm;
      default: ;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= '0;
      d_valid_q      <= 1'b0;
      d_hold_q       <= 1'b0;
      d_hold_instr_q <= '0;
      e_valid_q      <= 1'b0;
      e_instr_q      <= '0;
      acc_q          <= '0;
      carry_q        <= 1'b0;
      halted_q       <= 1'b0;
      retired_q      <= '0;
`ifdef PIPE_ACC_FWD_EN
      e_fwd_q        <= 1'b0;
      e_fwd_data_q   <= '0;
`endif
    end else if (!halted_q) begin
      if (e_valid_q) begin
        acc_q     <= acc_d;
        carry_q   <= carry_d;
        retired_q <= retired_q + 32'd1;
      end
      if (e_halt) begin
        halted_q  <= 1'b1;
        d_valid_q <= 1'b0;
        d_hold_q  <= 1'b0;
        e_valid_q <= 1'b0;
      end else if (e_taken) begin
        pc_q      <= e_a;
        d_valid_q <= 1'b0;
        d_hold_q  <= 1'b0;
        e_valid_q <= 1'b0;
      end else if (stall) begin
        d_hold_q       <= 1'b1;
        d_hold_instr_q <= d_instr;
        e_valid_q      <= 1'b0;
      end else begin
        pc_q      <= pc_q + AW'(1);
        d_valid_q <= 1'b1;
        d_hold_q  <= 1'b0;
        e_valid_q <= d_valid_q;
        e_instr_q <= d_instr;
`ifdef PIPE_ACC_FWD_EN
        e_fwd_q      <= hazard;
        e_fwd_data_q <= acc_q;
`endif
      end
    end
  end

endmodule
